// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame transmitter slice:
//   - frame FSM state encoding (IDLE / LOAD / WAIT / DONE)
//   - default header byte
//   - frame_len(): header + payload + checksum byte count
//   - bit_cycles(): sys_clk cycles per serial bit for a send_byte time_set
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   // Shortest bit period; each time_set step doubles it.
   localparam int unsigned BIT_BASE_CYCLES = 16;

   function automatic int unsigned frame_len(input int unsigned header_en,
                                             input int unsigned nbytes,
                                             input int unsigned csum_en);
      return header_en + nbytes + csum_en;
   endfunction

   function automatic int unsigned bit_cycles(input logic [2:0] time_set);
      return BIT_BASE_CYCLES << time_set;
   endfunction

endpackage

// File: rtl/send_byte.sv
// ---------------------------------------------------------------------------
// send_byte
// Single-byte 8N1 UART transmitter.
// Ports:
//   sys_clk   in   system clock
//   rst_n     in   asynchronous active-low reset (line forced high)
//   time_set  in   baud select, bit period = bit_cycles(time_set) clocks
//   data      in   byte to send, sampled on the send_go edge
//   send_go   in   single-cycle start request (ignored while sending)
//   uart_tx   out  serial line, idles high
//   tx_done   out  single-cycle pulse after the stop bit has completed
// ---------------------------------------------------------------------------
module send_byte
   import uart_pkg::*;
(
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [2:0] time_set,
   input  logic [7:0] data,
   input  logic       send_go,
   output logic       uart_tx,
   output logic       tx_done
);

   logic        active;
   logic [7:0]  data_r;
   logic [3:0]  bit_idx;   // 0 = start, 1..8 = data bits, 9 = stop
   logic [15:0] div_cnt;
   logic [15:0] div_last;

   always_comb div_last = 16'(bit_cycles(time_set) - 1);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         data_r  <= 8'h00;
         bit_idx <= 4'd0;
         div_cnt <= 16'd0;
         uart_tx <= 1'b1;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (!active) begin
            if (send_go) begin
               active  <= 1'b1;
               data_r  <= data;
               bit_idx <= 4'd0;
               div_cnt <= 16'd0;
               uart_tx <= 1'b0;
            end
         end else if (div_cnt == div_last) begin
            div_cnt <= 16'd0;
            if (bit_idx == 4'd9) begin
               active  <= 1'b0;
               tx_done <= 1'b1;
               uart_tx <= 1'b1;
            end else begin
               bit_idx <= bit_idx + 4'd1;
               // Leaving bit k presents bit k+1: data_r[k] for k<8, stop after.
               uart_tx <= (bit_idx == 4'd8) ? 1'b1 : data_r[bit_idx[2:0]];
            end
         end else begin
            div_cnt <= div_cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
// Multi-byte UART frame transmitter: [header] payload[0..NBYTES-1] [checksum]
// serialised through one send_byte.
// Ports:
//   sys_clk      in   system clock
//   rst_n        in   asynchronous active-low reset, aborts any frame
//   frame_data   in   payload word, byte p = frame_data[8p+7:8p]
//   frame_valid  in   send request (ignored when AUTO=1)
//   frame_ready  out  high in IDLE
//   busy         out  !frame_ready
//   frame_done   out  one-cycle pulse after the last stop bit
//   uart_tx      out  serial line, idles high
//   fsm_state    out  current FSM state (uart_pkg encoding), for debug
//
// Handshake: a frame is accepted on a rising sys_clk edge where frame_valid
// and frame_ready are both high. The sender keeps frame_valid and frame_data
// stable until that edge; there is no queueing, so a request made while busy
// simply waits. frame_data is copied into a shadow register at acceptance and
// is not looked at again until the next acceptance.
// ---------------------------------------------------------------------------
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int unsigned NBYTES    = 5,
   parameter int unsigned BAUD_SEL  = 2,
   parameter int unsigned HEADER_EN = 1,
   parameter logic [7:0]  HEADER    = DEFAULT_HEADER,
   parameter int unsigned CSUM_EN   = 1,
   parameter int unsigned LSB_FIRST = 1,
   parameter int unsigned AUTO      = 0
)(
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic [8*NBYTES-1:0]   frame_data,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  uart_tx,
   output logic [1:0]            fsm_state
);

   localparam int unsigned    FRAME_LEN = frame_len(HEADER_EN, NBYTES, CSUM_EN);
   localparam int unsigned    IDXW      = $clog2(FRAME_LEN + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

   logic [1:0]          state;
   logic [IDXW-1:0]     idx;
   logic [8*NBYTES-1:0] shadow;
   logic [7:0]          csum;
   logic [7:0]          tx_byte;
   logic                is_payload;
   logic                accept;
   logic                send_go;
   logic                tx_done;

   // Byte mux: frame index -> header, shadow payload byte, or checksum.
   always_comb begin
      int pos;
      int sel;
      pos = int'(idx) - int'(HEADER_EN);
      sel = (LSB_FIRST != 0) ? pos : int'(NBYTES) - 1 - pos;
      if (sel < 0 || sel >= int'(NBYTES)) sel = 0;
      tx_byte    = shadow[sel*8 +: 8];
      is_payload = 1'b1;
      if (HEADER_EN != 0 && idx == '0) begin
         tx_byte    = HEADER;
         is_payload = 1'b0;
      end else if (CSUM_EN != 0 && idx == LAST_IDX) begin
         tx_byte    = csum;
         is_payload = 1'b0;
      end
   end

   assign accept      = (state == IDLE) && ((AUTO != 0) || frame_valid);
   assign send_go     = (state == LOAD);
   assign frame_ready = (state == IDLE);
   assign busy        = !frame_ready;
   assign frame_done  = (state == DONE);
   assign fsm_state   = state;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         csum   <= 8'h00;
         shadow <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shadow <= frame_data;
                  csum   <= 8'h00;
                  idx    <= '0;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               // Checksum covers payload only; carry wraps modulo 256.
               if (is_payload) csum <= csum + tx_byte;
               state <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (idx == LAST_IDX) begin
                     state <= DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= LOAD;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   send_byte u_send_byte (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .time_set (3'(BAUD_SEL)),
      .data     (tx_byte),
      .send_go  (send_go),
      .uart_tx  (uart_tx),
      .tx_done  (tx_done)
   );

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
// Three frame transmitters driven side by side:
//   u_a  header + checksum, LSB-first payload
//   u_b  bare payload, MSB-first
//   u_c  free-running (AUTO=1)
// Each serial line feeds a bit-sampling receiver; decoded bytes are compared
// with frames built from the frame-format rules.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;
   import uart_pkg::*;

   localparam int NB  = 5;
   localparam int BIT = 16;   // sys_clk cycles per bit at BAUD_SEL = 0

   // ---------------- clock / reset ----------------
   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic rst_n, rst_n_c;
   logic [39:0] data_a, data_b, data_c;
   logic valid_a, valid_b, valid_c;
   logic ready_a, ready_b, ready_c;
   logic busy_a, busy_b, busy_c;
   logic done_a, done_b, done_c;
   logic tx_a, tx_b, tx_c;
   logic [1:0] st_a, st_b, st_c;

   uart_frame_tx #(.NBYTES(NB), .BAUD_SEL(0)) u_a (
      .sys_clk(sys_clk), .rst_n(rst_n), .frame_data(data_a), .frame_valid(valid_a),
      .frame_ready(ready_a), .busy(busy_a), .frame_done(done_a), .uart_tx(tx_a),
      .fsm_state(st_a));

   uart_frame_tx #(.NBYTES(NB), .BAUD_SEL(0), .HEADER_EN(0), .CSUM_EN(0),
                   .LSB_FIRST(0)) u_b (
      .sys_clk(sys_clk), .rst_n(rst_n), .frame_data(data_b), .frame_valid(valid_b),
      .frame_ready(ready_b), .busy(busy_b), .frame_done(done_b), .uart_tx(tx_b),
      .fsm_state(st_b));

   uart_frame_tx #(.NBYTES(NB), .BAUD_SEL(0), .AUTO(1)) u_c (
      .sys_clk(sys_clk), .rst_n(rst_n_c), .frame_data(data_c), .frame_valid(valid_c),
      .frame_ready(ready_c), .busy(busy_c), .frame_done(done_c), .uart_tx(tx_c),
      .fsm_state(st_c));

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q_a[$], rx_q_b[$], rx_q_c[$];
   int frm_err_a = 0, frm_err_b = 0, frm_err_c = 0;
   int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic line_of(input int w);
      case (w)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic done_of(input int w);
      case (w)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic int rx_count(input int w);
      case (w)
         0:       return rx_q_a.size();
         1:       return rx_q_b.size();
         default: return rx_q_c.size();
      endcase
   endfunction

   function automatic logic [7:0] rx_at(input int w, input int i);
      case (w)
         0:       return rx_q_a[i];
         1:       return rx_q_b[i];
         default: return rx_q_c[i];
      endcase
   endfunction

   // Reference frame: optional A5 header, payload bytes in the chosen order,
   // optional modulo-256 sum of the payload bytes.
   task automatic model_frame(input logic [39:0] d, input bit hdr, input bit cs, input bit lsb);
      logic [7:0] word_bytes[NB];
      int sum;
      sum = 0;
      for (int p = 0; p < NB; p++) word_bytes[p] = d[8*p +: 8];
      if (hdr) exp_q.push_back(8'hA5);
      for (int p = 0; p < NB; p++) begin
         logic [7:0] b;
         b = lsb ? word_bytes[p] : word_bytes[NB-1-p];
         exp_q.push_back(b);
         sum = sum + int'(b);
      end
      if (cs) exp_q.push_back(8'(sum % 256));
   endtask

   task automatic compare_rx(input int w, input int base, input string tag);
      check({tag, "_len"}, 32'(rx_count(w) - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < rx_count(w))
            check($sformatf("%s_b%0d", tag, i), 32'(rx_at(w, base + i)), 32'(exp_q[i]));
   endtask

   task automatic wait_done(input int w, input int budget, input string tag);
      int n;
      n = 0;
      while (done_of(w) !== 1'b1 && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_of(w) === 1'b1), 32'd1);
   endtask

   task automatic send_one(input int w, input logic [39:0] d);
      if (w == 0) begin data_a = d; valid_a = 1'b1; end
      else        begin data_b = d; valid_b = 1'b1; end
      @(negedge sys_clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
   endtask

   // ---------------- serial receivers (sample mid-bit on negedge) ----------------
   task automatic rx_byte(input int w, output logic [7:0] b, output bit ok);
      do @(negedge sys_clk); while (line_of(w) !== 1'b0);
      repeat (BIT/2) @(negedge sys_clk);
      ok = (line_of(w) === 1'b0);
      for (int i = 0; i < 8; i++) begin
         repeat (BIT) @(negedge sys_clk);
         b[i] = line_of(w);
      end
      repeat (BIT) @(negedge sys_clk);
      ok = ok && (line_of(w) === 1'b1);
   endtask

   initial forever begin : rx_mon_a
      logic [7:0] b; bit ok;
      rx_byte(0, b, ok);
      if (ok) rx_q_a.push_back(b); else frm_err_a++;
   end
   initial forever begin : rx_mon_b
      logic [7:0] b; bit ok;
      rx_byte(1, b, ok);
      if (ok) rx_q_b.push_back(b); else frm_err_b++;
   end
   initial forever begin : rx_mon_c
      logic [7:0] b; bit ok;
      rx_byte(2, b, ok);
      if (ok) rx_q_c.push_back(b); else frm_err_c++;
   end

   // frame_done must follow the last tx_done by exactly one cycle.
   logic txd_prev_a = 1'b0, txd_prev_b = 1'b0;
   // send_go spacing after tx_done on the free-running instance.
   int  since_c = 0, gap_viol_c = 0, gap_checks_c = 0;
   bit  pend_c = 1'b0, sawdone_c = 1'b0;

   always @(negedge sys_clk) begin
      if (done_a === 1'b1) begin
         done_cnt_a++;
         check("a_done_after_tx_done", 32'(txd_prev_a), 32'd1);
      end
      if (done_b === 1'b1) begin
         done_cnt_b++;
         check("b_done_after_tx_done", 32'(txd_prev_b), 32'd1);
      end
      if (done_c === 1'b1) done_cnt_c++;
      txd_prev_a = u_a.tx_done;
      txd_prev_b = u_b.tx_done;
      if (rst_n_c === 1'b1) begin
         since_c++;
         if (done_c === 1'b1) sawdone_c = 1'b1;
         if (u_c.send_go === 1'b1 && pend_c) begin
            gap_checks_c++;
            // Within a frame: 1 cycle. Across frames: DONE + IDLE + LOAD.
            if (since_c != (sawdone_c ? 3 : 1)) gap_viol_c++;
            pend_c = 1'b0;
         end
         if (u_c.tx_done === 1'b1) begin
            pend_c    = 1'b1;
            since_c   = 0;
            sawdone_c = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base, dbase;
      logic [39:0] d1, d2;

      rst_n = 1'b0; rst_n_c = 1'b0;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      data_a = '0; data_b = '0; data_c = 40'h1122334455;
      repeat (3) @(negedge sys_clk);

      // Reset values
      check("rst_ready_a", 32'(ready_a), 32'd1);
      check("rst_busy_a",  32'(busy_a),  32'd0);
      check("rst_done_a",  32'(done_a),  32'd0);
      check("rst_tx_a",    32'(tx_a),    32'd1);
      check("rst_state_a", 32'(st_a),    32'(IDLE));
      check("rst_tx_b",    32'(tx_b),    32'd1);
      check("rst_ready_b", 32'(ready_b), 32'd1);
      rst_n = 1'b1;
      @(negedge sys_clk);

      // Header + payload LSB first + checksum
      base = rx_q_a.size(); dbase = done_cnt_a;
      send_one(0, 40'h0504030201);
      check("t1_ready_low",  32'(ready_a),     32'd0);
      check("t1_busy_high",  32'(busy_a),      32'd1);
      check("t1_first_go",   32'(u_a.send_go), 32'd1);
      wait_done(0, 2000, "t1");
      check("t1_ready_at_done", 32'(ready_a), 32'd0);
      @(negedge sys_clk);
      check("t1_ready_back", 32'(ready_a), 32'd1);
      check("t1_done_pulse", 32'(done_a),  32'd0);
      repeat (20) @(negedge sys_clk);
      exp_q.delete();
      model_frame(40'h0504030201, 1, 1, 1);
      compare_rx(0, base, "t1");
      check("t1_csum_0f", 32'(rx_at(0, base + 6)), 32'h0F);
      check("t1_done_count", 32'(done_cnt_a - dbase), 32'd1);

      // Bare payload, MSB first
      base = rx_q_b.size(); dbase = done_cnt_b;
      send_one(1, 40'h0504030201);
      wait_done(1, 2000, "t2");
      check("t2_bytes_before_done", 32'(rx_q_b.size() - base), 32'd5);
      repeat (20) @(negedge sys_clk);
      exp_q.delete();
      model_frame(40'h0504030201, 0, 0, 0);
      compare_rx(1, base, "t2");
      check("t2_done_count", 32'(done_cnt_b - dbase), 32'd1);

      // Checksum wrap: FF FF 03 00 00 -> 01
      base = rx_q_a.size();
      send_one(0, 40'h000003FFFF);
      wait_done(0, 2000, "t3");
      repeat (20) @(negedge sys_clk);
      exp_q.delete();
      model_frame(40'h000003FFFF, 1, 1, 1);
      compare_rx(0, base, "t3");
      check("t3_csum_01", 32'(rx_at(0, base + 6)), 32'h01);

      // valid held, data changed mid-frame: original frame then one AA frame
      base = rx_q_a.size(); dbase = done_cnt_a;
      d1 = {8'($urandom), 32'($urandom)};
      data_a = d1; valid_a = 1'b1;
      repeat (50) @(negedge sys_clk);
      data_a = 40'hAAAAAAAAAA;
      wait_done(0, 2000, "t4a");
      @(negedge sys_clk);
      check("t4_idle_gap", 32'(ready_a), 32'd1);
      @(negedge sys_clk);
      check("t4_reaccept", 32'(ready_a), 32'd0);
      valid_a = 1'b0;
      wait_done(0, 2000, "t4b");
      repeat (300) @(negedge sys_clk);
      check("t4_done_count", 32'(done_cnt_a - dbase), 32'd2);
      check("t4_idle_after", 32'(ready_a), 32'd1);
      exp_q.delete();
      model_frame(d1, 1, 1, 1);
      model_frame(40'hAAAAAAAAAA, 1, 1, 1);
      compare_rx(0, base, "t4");

      // Reset during the third byte (payload byte 1 forced to 00 so line is low)
      dbase = done_cnt_a;
      d2 = {8'($urandom), 32'($urandom)};
      d2[15:8] = 8'h00;
      send_one(0, d2);
      repeat (400) @(negedge sys_clk);
      check("t5_line_low_before", 32'(tx_a), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("t5_line_high_async", 32'(tx_a),    32'd1);
      check("t5_ready_async",     32'(ready_a), 32'd1);
      check("t5_busy_async",      32'(busy_a),  32'd0);
      repeat (3) @(negedge sys_clk);
      rst_n = 1'b1;
      @(negedge sys_clk);
      check("t5_state_idle", 32'(st_a),    32'(IDLE));
      check("t5_ready_rel",  32'(ready_a), 32'd1);
      repeat (200) @(negedge sys_clk);
      check("t5_no_done", 32'(done_cnt_a - dbase), 32'd0);
      base = rx_q_a.size();
      d2 = {8'($urandom), 32'($urandom)};
      send_one(0, d2);
      wait_done(0, 2000, "t5");
      repeat (20) @(negedge sys_clk);
      exp_q.delete();
      model_frame(d2, 1, 1, 1);
      compare_rx(0, base, "t5");

      // Free-running: three identical frames
      base = rx_q_c.size();
      rst_n_c = 1'b1;
      for (int f = 0; f < 3; f++) begin
         wait_done(2, 2000, $sformatf("t6_f%0d", f));
         @(negedge sys_clk);
      end
      repeat (20) @(negedge sys_clk);
      exp_q.delete();
      for (int f = 0; f < 3; f++) model_frame(40'h1122334455, 1, 1, 1);
      compare_rx(2, base, "t6");
      check("t6_gap_checked", 32'(gap_checks_c >= 20), 32'd1);
      check("t6_gap_viol",    32'(gap_viol_c),         32'd0);

      check("frm_err_a", 32'(frm_err_a), 32'd0);
      check("frm_err_b", 32'(frm_err_b), 32'd0);
      check("frm_err_c", 32'(frm_err_c), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
